matrix_loader: RTL and testbench
================================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, listed first as: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 The module SHALL have: start  input  1  request to load one W/X operand pair.
REQ-003 The module SHALL have: abort  input  1  cancel the load in progress.
REQ-004 The module SHALL have: in_valid  input  1  host element valid.
REQ-005 The module SHALL have: in_data  input  4  host element, unsigned.
REQ-006 The module SHALL have: in_ready  output  1  loader accepts an element this cycle.
REQ-007 The module SHALL have: data_in  output  4  element driven to the memory bank.
REQ-008 The module SHALL have: row_w, col_w, row_x, col_x  output  2 each  element coordinates.
REQ-009 The module SHALL have: wr_w, wr_x  output  1 each  one-cycle write strobes, W bank and X bank.
REQ-010 The module SHALL have: clear_mem  output  1  memory-bank clear pulse.
REQ-011 The module SHALL have: busy  output  1  high in every state except IDLE.
REQ-012 The module SHALL have: done  output  1  one-cycle pulse when both matrices are loaded.

Function
REQ-013 The FSM SHALL have the states IDLE, CLEAR, LOAD_W, LOAD_X and DONE.
REQ-014 IDLE SHALL move to CLEAR when start=1; start SHALL be ignored in every other state.
REQ-015 CLEAR SHALL last exactly one cycle with clear_mem=1, then move to LOAD_W.
REQ-016 in_ready SHALL be 1 only in LOAD_W and LOAD_X; an element is accepted when in_valid and in_ready are both 1 in the same cycle.
REQ-017 Element ordering SHALL be row-major for both matrices: col increments 0..2, wraps to 0 and increments row; coordinate value 3 SHALL never be driven.
REQ-018 Every accepted element SHALL be registered with latency 1: in the next cycle data_in=in_data, the matching coordinates are driven, and exactly one of wr_w/wr_x is 1.
REQ-019 Outputs SHALL hold their last values between accepts, and strobes SHALL be 0 when no element was accepted in the previous cycle.
REQ-020 The 9th accepted element in LOAD_W SHALL move the FSM to LOAD_X, and the 9th in LOAD_X SHALL move it to DONE.
REQ-021 The element counter SHALL be 4 bits wide, range 0..8, and reset to 0 on each matrix switch.
REQ-022 DONE SHALL last one cycle with done=1, and the FSM SHALL then return to IDLE.
REQ-023 A final accept and its write strobe SHALL precede done by at least one cycle.
REQ-024 abort=1 in any non-IDLE state SHALL force IDLE on the next edge; done SHALL stay 0 and a pending strobe from a same-cycle accept SHALL still issue.
REQ-025 When abort and in_valid are 1 in the same cycle, abort SHALL win: the element SHALL NOT be accepted and in_ready SHALL be 0 that cycle.
REQ-026 Stalls SHALL be allowed: in_valid=0 for any number of cycles SHALL leave the state and counters unchanged.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately force IDLE and clear all counters.
REQ-028 While rst_n=0, all outputs SHALL be 0, including data_in, the coordinates, the strobes, clear_mem, busy, done and in_ready.
REQ-029 A reset mid-load SHALL discard the partial load, and no done SHALL follow.
REQ-030 The first start after reset release SHALL behave as a fresh load.

Configuration
REQ-031 With MATRIX_LOADER_XCOLMAJOR_EN defined, X elements SHALL be ordered column-major: row increments first, col after wrap.
REQ-032 W ordering SHALL be row-major in both builds.
REQ-033 Without MATRIX_LOADER_XCOLMAJOR_EN, both matrices SHALL be row-major, and no other behaviour SHALL change between builds.

Structure
REQ-034 The shared package matmul_pkg SHALL hold DIM=3, ELEM_W=4, RES_W=10, the element-count constant NELEM=9, and the loader state enum.
REQ-035 The design SHALL contain one sub-module, matrix_loader_idx, a 2-D row/col wrap counter with order-select input, instantiated once and reused for W and X.

Verification
REQ-036 Reset then start, with 18 back-to-back elements 1..15,0,1,2: the bench SHALL see clear_mem high for 1 cycle, then wr_w for elements 1..9 at (0,0)..(2,2), wr_x for the rest, and done exactly 1 cycle after the last wr_x.
REQ-037 Random in_valid gaps (50% duty): the bench SHALL see the same data/coordinate sequence as REQ-036 and no strobe in any gap cycle.
REQ-038 abort after the 5th W element: the bench SHALL see busy=0 next cycle, done never asserted, and a subsequent start reloading from (0,0) with clear_mem.
REQ-039 rst_n dropped mid-LOAD_X: the bench SHALL see all outputs 0 asynchronously and no done after release.
REQ-040 start pulsed during LOAD_W: the bench SHALL see no effect and no second clear_mem.
REQ-041 With MATRIX_LOADER_XCOLMAJOR_EN: the bench SHALL see the X coordinate sequence (0,0),(1,0),(2,0),(0,1)... while W stays row-major.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants and the loader state encoding for the matrix-multiply datapath.
package matmul_pkg;

    localparam int DIM    = 3;
    localparam int ELEM_W = 4;
    localparam int RES_W  = 10;
    localparam int NELEM  = DIM * DIM;
    localparam int CNT_W  = 4;
    localparam int IDX_W  = 2;

    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(DIM - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NELEM - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD_W,
        ST_LOAD_X,
        ST_DONE
    } loader_state_e;

endpackage

// File: rtl/matrix_loader_idx.sv
// 2-D row/col wrap counter; col_major selects which coordinate advances first.
module matrix_loader_idx
    import matmul_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             col_major,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col
);

    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (inc) begin
            if (col_major) begin
                if (row_q == IDX_MAX) begin
                    row_d = '0;
                    col_d = (col_q == IDX_MAX) ? '0 : col_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                if (col_q == IDX_MAX) begin
                    col_d = '0;
                    row_d = (row_q == IDX_MAX) ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row = row_q;
    assign col = col_q;

endmodule

// File: rtl/matrix_loader.sv
// Streams one 3x3 W and one 3x3 X operand into the memory banks, one element per accept.
// Define MATRIX_LOADER_XCOLMAJOR_EN to load X column-major (W stays row-major).
module matrix_loader
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [ELEM_W-1:0] in_data,
    output logic              in_ready,
    output logic [ELEM_W-1:0] data_in,
    output logic [IDX_W-1:0]  row_w,
    output logic [IDX_W-1:0]  col_w,
    output logic [IDX_W-1:0]  row_x,
    output logic [IDX_W-1:0]  col_x,
    output logic              wr_w,
    output logic              wr_x,
    output logic              clear_mem,
    output logic              busy,
    output logic              done
);

    loader_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [ELEM_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  row_w_q, row_w_d, col_w_q, col_w_d;
    logic [IDX_W-1:0]  row_x_q, row_x_d, col_x_q, col_x_d;
    logic              wr_w_q, wr_w_d, wr_x_q, wr_x_d;

    logic             loading, accept, acc_w, acc_x, last_elem;
    logic             idx_clr, col_major;
    logic [IDX_W-1:0] idx_row, idx_col;

    // last_q holds LOAD_X for one drain cycle so the final wr_x precedes done.
    assign loading   = (state_q == ST_LOAD_W) || ((state_q == ST_LOAD_X) && !last_q);
    assign in_ready  = loading && !abort;
    assign accept    = in_valid && in_ready;
    assign acc_w     = accept && (state_q == ST_LOAD_W);
    assign acc_x     = accept && (state_q == ST_LOAD_X);
    assign last_elem = (cnt_q == CNT_LAST);
    assign idx_clr   = (state_q == ST_CLEAR) || (accept && last_elem);

`ifdef MATRIX_LOADER_XCOLMAJOR_EN
    assign col_major = (state_q == ST_LOAD_X);
`else
    assign col_major = 1'b0;
`endif

    matrix_loader_idx u_idx (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (idx_clr),
        .inc       (accept),
        .col_major (col_major),
        .row       (idx_row),
        .col       (idx_col)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_CLEAR;
            ST_CLEAR: begin
                cnt_d   = '0;
                last_d  = 1'b0;
                state_d = ST_LOAD_W;
            end
            ST_LOAD_W: if (accept) begin
                if (last_elem) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD_X;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOAD_X: begin
                if (last_q) begin
                    last_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (accept) begin
                    if (last_elem) begin
                        cnt_d  = '0;
                        last_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            last_d  = 1'b0;
        end
    end

    always_comb begin
        data_d  = accept ? in_data : data_q;
        row_w_d = acc_w ? idx_row : row_w_q;
        col_w_d = acc_w ? idx_col : col_w_q;
        row_x_d = acc_x ? idx_row : row_x_q;
        col_x_d = acc_x ? idx_col : col_x_q;
        wr_w_d  = acc_w;
        wr_x_d  = acc_x;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            data_q  <= '0;
            row_w_q <= '0;
            col_w_q <= '0;
            row_x_q <= '0;
            col_x_q <= '0;
            wr_w_q  <= 1'b0;
            wr_x_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            data_q  <= data_d;
            row_w_q <= row_w_d;
            col_w_q <= col_w_d;
            row_x_q <= row_x_d;
            col_x_q <= col_x_d;
            wr_w_q  <= wr_w_d;
            wr_x_q  <= wr_x_d;
        end
    end

    assign data_in   = data_q;
    assign row_w     = row_w_q;
    assign col_w     = col_w_q;
    assign row_x     = row_x_q;
    assign col_x     = col_x_q;
    assign wr_w      = wr_w_q;
    assign wr_x      = wr_x_q;
    assign clear_mem = (state_q == ST_CLEAR);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_matrix_loader.sv
// Directed self-checking bench for matrix_loader: full loads, gaps, abort, reset, start glitch.
module tb_matrix_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_ready, wr_w, wr_x, clear_mem, busy, done;
    logic [3:0] data_in;
    logic [1:0] row_w, col_w, row_x, col_x;

    matrix_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .row_w     (row_w),
        .col_w     (col_w),
        .row_x     (row_x),
        .col_x     (col_x),
        .wr_w      (wr_w),
        .wr_x      (wr_x),
        .clear_mem (clear_mem),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected held output values.
    logic [3:0] exp_data;
    logic [1:0] exp_rw, exp_cw, exp_rx, exp_cx;
    logic       exp_ww, exp_wx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] elem_val(input int k);
        return 4'((k + 1) % 16);
    endfunction

    function automatic logic [17:0] all_outs();
        return {in_ready, clear_mem, busy, done, wr_w, wr_x, data_in, row_w, col_w, row_x, col_x};
    endfunction

    function automatic logic [16:0] obs_vec();
        return {clear_mem, busy, done, wr_w, wr_x, data_in, row_w, col_w, row_x, col_x};
    endfunction

    function automatic logic [16:0] exp_vec(input logic e_busy, input logic e_done);
        return {1'b0, e_busy, e_done, exp_ww, exp_wx, exp_data, exp_rw, exp_cw, exp_rx, exp_cx};
    endfunction

    task automatic model_reset();
        exp_data = '0; exp_rw = '0; exp_cw = '0; exp_rx = '0; exp_cx = '0;
        exp_ww = 1'b0; exp_wx = 1'b0;
    endtask

    task automatic model_accept(input int j);
        int jj;
        exp_data = elem_val(j);
        exp_ww = (j < 9);
        exp_wx = (j >= 9);
        if (j < 9) begin
            exp_rw = 2'(j / 3);
            exp_cw = 2'(j % 3);
        end else begin
            jj = j - 9;
`ifdef MATRIX_LOADER_XCOLMAJOR_EN
            exp_rx = 2'(jj % 3);
            exp_cx = 2'(jj / 3);
`else
            exp_rx = 2'(jj / 3);
            exp_cx = 2'(jj % 3);
`endif
        end
    endtask

    // Starts a load and streams elements 0..stop_at-1; start re-pulsed while k==glitch_at.
    task automatic do_load(input bit gaps, input int stop_at, input int glitch_at);
        int  k = 0;
        int  budget = 0;
        bit  acc;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("clear_mem_pulse", clear_mem, 1'b1);
        check("busy_in_clear", busy, 1'b1);
        tick();
        while (k < stop_at && budget < 200) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = elem_val(k);
            start    = (k == glitch_at);
            #1;
            check("in_ready_load", in_ready, 1'b1);
            acc = in_valid;
            tick();
            budget++;
            exp_ww = 1'b0;
            exp_wx = 1'b0;
            if (acc) begin
                model_accept(k);
                k++;
            end
            check("stream_vec", obs_vec(), exp_vec(1'b1, 1'b0));
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("load_budget", k, stop_at);
    endtask

    task automatic finish_load();
        tick();
        exp_ww = 1'b0;
        exp_wx = 1'b0;
        check("done_pulse", obs_vec(), exp_vec(1'b1, 1'b1));
        tick();
        check("idle_after_done", obs_vec(), exp_vec(1'b0, 1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_done;
        model_reset();

        // Reset state: all outputs low even with stimulus applied.
        in_valid = 1'b1;
        start = 1'b1;
        #3;
        check("reset_outs", all_outs(), 18'h0);
        start = 1'b0;
        in_valid = 1'b0;
        #4 rst_n = 1'b1;
        tick();
        check("idle_outs", all_outs(), 18'h0);

        // Back-to-back full load.
        do_load(1'b0, 18, -1);
        finish_load();

        // Random gaps plus a start pulse during LOAD_W.
        do_load(1'b1, 18, 4);
        finish_load();

        // Abort after the 5th W element, with in_valid held in the abort cycle.
        do_load(1'b0, 5, -1);
        abort = 1'b1;
        in_valid = 1'b1;
        in_data = 4'hA;
        #1;
        check("in_ready_abort", in_ready, 1'b0);
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        exp_ww = 1'b0;
        exp_wx = 1'b0;
        check("abort_idle", obs_vec(), exp_vec(1'b0, 1'b0));
        seen_done = 1'b0;
        repeat (5) begin
            tick();
            seen_done |= done;
        end
        check("no_done_after_abort", seen_done, 1'b0);
        do_load(1'b0, 18, -1);
        finish_load();

        // Reset mid-LOAD_X.
        do_load(1'b0, 12, -1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outs", all_outs(), 18'h0);
        model_reset();
        tick();
        #2 rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (10) begin
            tick();
            seen_done |= done;
        end
        check("no_done_after_reset", seen_done, 1'b0);
        check("idle_after_reset", all_outs(), 18'h0);
        do_load(1'b0, 18, -1);
        finish_load();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
